// File: rtl/control_unit.sv
// Multicycle fetch/decode/control stage for an RV32I subset: owns PC and IR, sequences datapath controls.
// Optional feature: define ILLEGAL_TRAP_EN to trap illegal instructions into HALT with a sticky Illegal flag.
module control_unit #(
  parameter int unsigned NBITS      = 8,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned WIDTH_ALUF = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              Instr,
  output logic [NBITS-1:0]         PC,
  input  logic                     Zero,
  input  logic [NBITS-1:0]         PCReg,
  output logic [$clog2(NREGS)-1:0] RS1,
  output logic [$clog2(NREGS)-1:0] RS2,
  output logic [$clog2(NREGS)-1:0] RD,
  output logic [NBITS-1:0]         IMM,
  output logic [WIDTH_ALUF-1:0]    ALUControl,
  output logic                     ALUSrc,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     link,
  output logic [NBITS-1:0]         pclink,
  output logic                     MemRead,
  output logic                     MemWrite,
  input  logic                     MemReady,
  output logic                     Illegal
);

  localparam int unsigned IW = $clog2(NREGS);
  localparam logic [WIDTH_ALUF-1:0] ALU_ADD = WIDTH_ALUF'(0);
  localparam logic [WIDTH_ALUF-1:0] ALU_AND = WIDTH_ALUF'(7);
  localparam logic [WIDTH_ALUF-1:0] ALU_SUB = WIDTH_ALUF'(8);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [3:0] {OP_ADD, OP_AND, OP_ADDI, OP_ANDI, OP_LW, OP_SW,
                            OP_BEQ, OP_JAL, OP_JALR, OP_BAD} op_t;

  state_t                state, state_nxt;
  op_t                   op_c;
  logic [31:0]           ir;
  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [NBITS-1:0]      imm_c, pc_nxt, pc_inc;
  logic [WIDTH_ALUF-1:0] alu_nxt;
  logic                  src_nxt, m2r_nxt, rw_nxt, link_nxt, mr_nxt, mw_nxt;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign pc_inc = PC + NBITS'(4);

  // Instruction class and immediate, decoded from the held IR
  always_comb begin
    op_c = OP_BAD;
    case (opcode)
      7'b0110011: if (f7 == 7'd0) begin
                    if (f3 == 3'b000)      op_c = OP_ADD;
                    else if (f3 == 3'b111) op_c = OP_AND;
                  end
      7'b0010011: if (f3 == 3'b000)      op_c = OP_ADDI;
                  else if (f3 == 3'b111) op_c = OP_ANDI;
      7'b0000011: if (f3 == 3'b010) op_c = OP_LW;
      7'b0100011: if (f3 == 3'b010) op_c = OP_SW;
      7'b1100011: if (f3 == 3'b000) op_c = OP_BEQ;
      7'b1101111: op_c = OP_JAL;
      7'b1100111: if (f3 == 3'b000) op_c = OP_JALR;
      default:    op_c = OP_BAD;
    endcase

    imm_c = '0;
    case (op_c)
      OP_ADDI, OP_ANDI, OP_LW, OP_JALR:
        imm_c = NBITS'({{20{ir[31]}}, ir[31:20]});
      OP_SW:  imm_c = NBITS'({{20{ir[31]}}, ir[31:25], ir[11:7]});
      OP_BEQ: imm_c = NBITS'({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      OP_JAL: imm_c = NBITS'({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
      default: imm_c = '0;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_nxt;
`endif

  // Next state and PC, then the control word for the state being entered
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    alu_nxt   = ALU_ADD;
    src_nxt   = 1'b0;
    m2r_nxt   = 1'b0;
    rw_nxt    = 1'b0;
    link_nxt  = 1'b0;
    mr_nxt    = 1'b0;
    mw_nxt    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_nxt = Illegal;
`endif

    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        if (op_c == OP_LW || op_c == OP_SW) begin
          state_nxt = MEM;
        end else if (op_c == OP_BAD) begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt   = HALT;
          illegal_nxt = 1'b1;
`else
          state_nxt = FETCH;
          pc_nxt    = pc_inc;
`endif
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = FETCH;
        case (op_c)
          OP_BEQ:  pc_nxt = Zero ? PC + imm_c : pc_inc;
          OP_JAL:  pc_nxt = PC + imm_c;
          OP_JALR: pc_nxt = (PCReg + imm_c) & ~NBITS'(1);
          default: pc_nxt = pc_inc;
        endcase
      end
      MEM: begin
        if (MemReady) begin
          if (op_c == OP_LW) begin
            state_nxt = WB;
          end else begin
            state_nxt = FETCH;
            pc_nxt    = pc_inc;
          end
        end
      end
      WB: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase

    case (state_nxt)
      EXEC: begin
        case (op_c)
          OP_ADD:  rw_nxt = 1'b1;
          OP_AND:  begin alu_nxt = ALU_AND; rw_nxt = 1'b1; end
          OP_ADDI: begin src_nxt = 1'b1; rw_nxt = 1'b1; end
          OP_ANDI: begin alu_nxt = ALU_AND; src_nxt = 1'b1; rw_nxt = 1'b1; end
          OP_BEQ:  alu_nxt = ALU_SUB;
          OP_JAL:  begin link_nxt = 1'b1; rw_nxt = 1'b1; end
          OP_JALR: begin link_nxt = 1'b1; rw_nxt = 1'b1; src_nxt = 1'b1; end
          default: ;
        endcase
      end
      MEM: begin
        src_nxt = 1'b1;
        mr_nxt  = (op_c == OP_LW);
        mw_nxt  = (op_c == OP_SW);
      end
      WB: begin
        m2r_nxt = 1'b1;
        rw_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, PC/IR and registered control outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FETCH;
      PC         <= '0;
      pclink     <= NBITS'(4);
      ir         <= '0;
      RS1        <= '0;
      RS2        <= '0;
      RD         <= '0;
      IMM        <= '0;
      ALUControl <= ALU_ADD;
      ALUSrc     <= 1'b0;
      MemtoReg   <= 1'b0;
      RegWrite   <= 1'b0;
      link       <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
    end else begin
      state      <= state_nxt;
      PC         <= pc_nxt;
      pclink     <= pc_nxt + NBITS'(4);
      ALUControl <= alu_nxt;
      ALUSrc     <= src_nxt;
      MemtoReg   <= m2r_nxt;
      RegWrite   <= rw_nxt;
      link       <= link_nxt;
      MemRead    <= mr_nxt;
      MemWrite   <= mw_nxt;
      if (state == FETCH) ir <= Instr;
      if (state == DECODE) begin
        RS1 <= IW'(ir[19:15]);
        RS2 <= IW'(ir[24:20]);
        RD  <= IW'(ir[11:7]);
        IMM <= imm_c;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset) Illegal <= 1'b0;
    else       Illegal <= illegal_nxt;
  end
`else
  assign Illegal = 1'b0;
`endif

endmodule
